// File: rtl/gpmc_csr_bridge.sv
// GPMC-to-CSR bridge: oversampled async GPMC bus driving a multi-region CSR bus.
// Optional burst auto-increment is enabled by defining GPMC_CSR_BURST_EN.
module gpmc_csr_bridge #(
  parameter int AW          = 14,
  parameter int NCS         = 2,
  parameter int CSR_LAT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  output logic [NCS-1:0] csr_cs,
  output logic [AW-1:0]  csr_adr,
  output logic           csr_we,
  output logic           csr_re,
  output logic [15:0]    csr_dat_w,
  input  logic [15:0]    csr_dat_r,
  input  logic [9:0]     gpmc_a,
  input  logic [15:0]    gpmc_d_i,
  output logic [15:0]    gpmc_d_o,
  output logic           gpmc_d_oe,
  input  logic           gpmc_we_n,
  input  logic           gpmc_oe_n,
  input  logic           gpmc_ale_n,
  input  logic [NCS-1:0] gpmc_cs_n,
  output logic           gpmc_wait
);

  localparam int IW = 29 + NCS;
  localparam logic [IW-1:0] IRST = {{26{1'b0}}, {(3 + NCS){1'b1}}};

  typedef enum logic [2:0] {
    IDLE, ADDR, WRITE, RD_ISSUE, RD_WAIT, RD_DRIVE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0][IW-1:0] sync_q;
  logic [IW-1:0]  in_vec;
  logic [9:0]     a_s;
  logic [15:0]    d_s;
  logic           we_s, oe_s, ale_s;
  logic [NCS-1:0] cs_s;
  logic           we_h, oe_h;
  logic           we_fall, oe_fall, oe_rise;
  logic [NCS-1:0] sel_n;
  logic           cs_drop;
  logic [1:0]     cnt;
`ifdef GPMC_CSR_BURST_EN
  logic           first;
`endif

  assign in_vec = {gpmc_a, gpmc_d_i, gpmc_we_n, gpmc_oe_n, gpmc_ale_n, gpmc_cs_n};
  assign {a_s, d_s, we_s, oe_s, ale_s, cs_s} = sync_q[SYNC_STAGES-1];

  assign we_fall = we_h & ~we_s;
  assign oe_fall = oe_h & ~oe_s;
  assign oe_rise = ~oe_h & oe_s;
  assign cs_drop = |(csr_cs & cs_s);

  // Input synchroniser chain plus edge-history flops; active-low lines idle high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_q <= {SYNC_STAGES{IRST}};
      we_h   <= 1'b1;
      oe_h   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_vec};
      we_h   <= we_s;
      oe_h   <= oe_s;
    end
  end

  // Lowest-index asserted chip select wins.
  always_comb begin
    sel_n = '0;
    for (int i = NCS - 1; i >= 0; i--) begin
      if (!cs_s[i]) begin
        sel_n    = '0;
        sel_n[i] = 1'b1;
      end
    end
  end

  // Bridge FSM with registered CSR and pad-side outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      csr_cs    <= '0;
      csr_adr   <= '0;
      csr_we    <= 1'b0;
      csr_re    <= 1'b0;
      csr_dat_w <= '0;
      gpmc_d_o  <= '0;
      gpmc_d_oe <= 1'b0;
      gpmc_wait <= 1'b0;
      cnt       <= '0;
`ifdef GPMC_CSR_BURST_EN
      first     <= 1'b1;
`endif
    end else begin
      csr_we <= 1'b0;
      csr_re <= 1'b0;
      if (state != IDLE && cs_drop) begin
        state     <= IDLE;
        csr_cs    <= '0;
        gpmc_d_oe <= 1'b0;
        gpmc_wait <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!(&cs_s)) begin
              state  <= ADDR;
              csr_cs <= sel_n;
`ifdef GPMC_CSR_BURST_EN
              first  <= 1'b1;
`endif
            end
          end
          ADDR: begin
            if (!ale_s) begin
              csr_adr <= AW'({a_s, d_s});
`ifdef GPMC_CSR_BURST_EN
              first   <= 1'b1;
`endif
            end else if (we_fall) begin
              state     <= WRITE;
              csr_we    <= 1'b1;
              csr_dat_w <= d_s;
`ifdef GPMC_CSR_BURST_EN
              if (!first) csr_adr <= csr_adr + AW'(1);
              first <= 1'b0;
`endif
            end else if (oe_fall) begin
              state     <= RD_ISSUE;
              csr_re    <= 1'b1;
              gpmc_wait <= 1'b1;
              cnt       <= '0;
`ifdef GPMC_CSR_BURST_EN
              if (!first) csr_adr <= csr_adr + AW'(1);
              first <= 1'b0;
`endif
            end
          end
          WRITE: state <= ADDR;
          RD_ISSUE: begin
            if (cnt == 2'(CSR_LAT - 1)) begin
              gpmc_d_o <= csr_dat_r;
              state    <= RD_WAIT;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
          RD_WAIT: begin
            gpmc_d_oe <= 1'b1;
            gpmc_wait <= 1'b0;
            state     <= RD_DRIVE;
          end
          RD_DRIVE: begin
            if (oe_rise) begin
              gpmc_d_oe <= 1'b0;
              state     <= ADDR;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpmc_csr_bridge.sv
// Directed testbench for gpmc_csr_bridge (CSR_LAT=3, SYNC_STAGES=2).
// Pins are driven on falling edges; a monitor samples 1ns after rising edges.
module tb_gpmc_csr_bridge;
  localparam int AW  = 14;
  localparam int NCS = 2;
  localparam int LAT = 3;
  localparam int SS  = 2;

  logic           clk = 1'b0;
  logic           sys_rst;
  logic [NCS-1:0] csr_cs;
  logic [AW-1:0]  csr_adr;
  logic           csr_we, csr_re;
  logic [15:0]    csr_dat_w, csr_dat_r;
  logic [9:0]     gpmc_a;
  logic [15:0]    gpmc_d_i, gpmc_d_o;
  logic           gpmc_d_oe, gpmc_we_n, gpmc_oe_n, gpmc_ale_n, gpmc_wait;
  logic [NCS-1:0] gpmc_cs_n;

  always #5 clk = ~clk;

  gpmc_csr_bridge #(.AW(AW), .NCS(NCS), .CSR_LAT(LAT), .SYNC_STAGES(SS)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .csr_cs(csr_cs), .csr_adr(csr_adr), .csr_we(csr_we), .csr_re(csr_re),
    .csr_dat_w(csr_dat_w), .csr_dat_r(csr_dat_r),
    .gpmc_a(gpmc_a), .gpmc_d_i(gpmc_d_i), .gpmc_d_o(gpmc_d_o),
    .gpmc_d_oe(gpmc_d_oe), .gpmc_we_n(gpmc_we_n), .gpmc_oe_n(gpmc_oe_n),
    .gpmc_ale_n(gpmc_ale_n), .gpmc_cs_n(gpmc_cs_n), .gpmc_wait(gpmc_wait)
  );

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, re_cnt = 0, wait_cnt = 0, oe_cnt = 0;
  logic [AW-1:0]  adr_q[$];
  logic [15:0]    dat_q[$];
  logic [NCS-1:0] cs_q[$];

  // Record every strobe and busy/drive cycle away from the active edge.
  always begin
    @(posedge clk);
    #1;
    if (csr_we) begin
      we_cnt++;
      adr_q.push_back(csr_adr);
      dat_q.push_back(csr_dat_w);
      cs_q.push_back(csr_cs);
    end
    if (csr_re) re_cnt++;
    if (gpmc_wait) wait_cnt++;
    if (gpmc_d_oe) oe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bus();
    gpmc_cs_n  = '1;
    gpmc_we_n  = 1'b1;
    gpmc_oe_n  = 1'b1;
    gpmc_ale_n = 1'b1;
    tick(6);
  endtask

  task automatic open_acc(input logic [NCS-1:0] cs, input logic [25:0] a);
    gpmc_cs_n = cs;
    tick(2);
    {gpmc_a, gpmc_d_i} = a;
    gpmc_ale_n = 1'b0;
    tick(1);
    gpmc_ale_n = 1'b1;
    tick(2);
  endtask

  task automatic wr(input logic [15:0] d);
    gpmc_d_i  = d;
    gpmc_we_n = 1'b0;
    tick(SS + 3);
    gpmc_we_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    tick(3);
    checks++;
    if ({csr_cs, csr_adr, csr_we, csr_re, csr_dat_w, gpmc_d_o, gpmc_d_oe, gpmc_wait} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got cs=%h adr=%h we=%b re=%b dw=%h do=%h oe=%b wait=%b required all 0",
               csr_cs, csr_adr, csr_we, csr_re, csr_dat_w, gpmc_d_o, gpmc_d_oe, gpmc_wait);
    end
    sys_rst = 1'b0;
    tick(2);
  endtask

  task automatic test_write();
    int w0;
    open_acc(2'b10, 26'h0123);
    w0 = we_cnt;
    gpmc_d_i  = 16'hBEEF;
    gpmc_we_n = 1'b0;
    tick(SS);
    checks++;
    if (csr_we !== 1'b0) begin
      errors++;
      $display("FAIL write_early: csr_we=%b required 0", csr_we);
    end
    tick(1);
    checks++;
    if (csr_we !== 1'b1) begin
      errors++;
      $display("FAIL write_strobe: csr_we=%b required 1", csr_we);
    end
    checks++;
    if ({csr_cs, csr_adr, csr_dat_w} !== {2'b01, 14'h0123, 16'hBEEF}) begin
      errors++;
      $display("FAIL write_fields: cs=%b adr=%h dat=%h required cs=01 adr=0123 dat=beef",
               csr_cs, csr_adr, csr_dat_w);
    end
    tick(1);
    checks++;
    if (csr_we !== 1'b0) begin
      errors++;
      $display("FAIL write_pulse_width: csr_we=%b required 0", csr_we);
    end
    tick(2);
    gpmc_we_n = 1'b1;
    tick(3);
    checks++;
    if (we_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL write_count: got %0d pulses required 1", we_cnt - w0);
    end
    idle_bus();
  endtask

  task automatic test_read();
    int w0, r0;
    open_acc(2'b01, 26'h0040);
    csr_dat_r = 16'h1234;
    w0 = wait_cnt;
    r0 = re_cnt;
    gpmc_oe_n = 1'b0;
    tick(SS);
    checks++;
    if ({csr_re, gpmc_wait} !== 2'b00) begin
      errors++;
      $display("FAIL read_early: re=%b wait=%b required 0 0", csr_re, gpmc_wait);
    end
    tick(1);
    checks++;
    if ({csr_re, gpmc_wait, csr_cs, csr_adr} !== {1'b1, 1'b1, 2'b10, 14'h0040}) begin
      errors++;
      $display("FAIL read_issue: re=%b wait=%b cs=%b adr=%h required 1 1 10 0040",
               csr_re, gpmc_wait, csr_cs, csr_adr);
    end
    tick(1);
    checks++;
    if ({csr_re, gpmc_wait} !== 2'b01) begin
      errors++;
      $display("FAIL read_re_pulse: re=%b wait=%b required 0 1", csr_re, gpmc_wait);
    end
    tick(LAT);
    checks++;
    if ({gpmc_d_oe, gpmc_wait, gpmc_d_o} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL read_data: oe=%b wait=%b do=%h required 1 0 1234",
               gpmc_d_oe, gpmc_wait, gpmc_d_o);
    end
    tick(3);
    checks++;
    if (gpmc_d_oe !== 1'b1) begin
      errors++;
      $display("FAIL read_hold: oe=%b required 1", gpmc_d_oe);
    end
    checks++;
    if (wait_cnt - w0 !== 4) begin
      errors++;
      $display("FAIL read_wait_len: got %0d cycles required 4", wait_cnt - w0);
    end
    checks++;
    if (re_cnt - r0 !== 1) begin
      errors++;
      $display("FAIL read_re_count: got %0d required 1", re_cnt - r0);
    end
    gpmc_oe_n = 1'b1;
    tick(SS);
    checks++;
    if (gpmc_d_oe !== 1'b1) begin
      errors++;
      $display("FAIL read_oe_early_drop: oe=%b required 1", gpmc_d_oe);
    end
    tick(1);
    checks++;
    if (gpmc_d_oe !== 1'b0) begin
      errors++;
      $display("FAIL read_oe_release: oe=%b required 0", gpmc_d_oe);
    end
    csr_dat_r = '0;
    idle_bus();
  endtask

  task automatic test_burst();
    int n0;
    logic [AW-1:0] exp_adr [3];
`ifdef GPMC_CSR_BURST_EN
    exp_adr = '{14'h3FFF, 14'h0000, 14'h0001};
`else
    exp_adr = '{14'h3FFF, 14'h3FFF, 14'h3FFF};
`endif
    open_acc(2'b10, 26'h0003FFF);
    n0 = adr_q.size();
    wr(16'h0001);
    wr(16'h0002);
    wr(16'h0003);
    checks++;
    if (adr_q.size() - n0 !== 3) begin
      errors++;
      $display("FAIL burst_count: got %0d writes required 3", adr_q.size() - n0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({adr_q[n0 + i], dat_q[n0 + i]} !== {exp_adr[i], 16'(i + 1)}) begin
          errors++;
          $display("FAIL burst_w%0d: adr=%h dat=%h required adr=%h dat=%h",
                   i, adr_q[n0 + i], dat_q[n0 + i], exp_adr[i], 16'(i + 1));
        end
      end
    end
    idle_bus();
  endtask

  task automatic test_cs_priority();
    int n0;
    open_acc(2'b00, 26'h0ABC);
    n0 = adr_q.size();
    wr(16'h5A5A);
    checks++;
    if (adr_q.size() - n0 !== 1) begin
      errors++;
      $display("FAIL prio_count: got %0d writes required 1", adr_q.size() - n0);
    end else begin
      checks++;
      if ({cs_q[n0], adr_q[n0], dat_q[n0]} !== {2'b01, 14'h0ABC, 16'h5A5A}) begin
        errors++;
        $display("FAIL prio_fields: cs=%b adr=%h dat=%h required 01 0abc 5a5a",
                 cs_q[n0], adr_q[n0], dat_q[n0]);
      end
    end
    idle_bus();
  endtask

  task automatic test_read_abort();
    int o0;
    open_acc(2'b10, 26'h0007);
    csr_dat_r = 16'hCAFE;
    o0 = oe_cnt;
    gpmc_oe_n = 1'b0;
    tick(SS + 1);
    checks++;
    if (csr_re !== 1'b1) begin
      errors++;
      $display("FAIL abort_re: re=%b required 1", csr_re);
    end
    gpmc_cs_n = '1;
    tick(8);
    checks++;
    if (oe_cnt - o0 !== 0) begin
      errors++;
      $display("FAIL abort_oe: oe high %0d cycles required 0", oe_cnt - o0);
    end
    checks++;
    if ({gpmc_wait, gpmc_d_oe, csr_cs} !== {1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL abort_idle: wait=%b oe=%b cs=%b required 0 0 00",
               gpmc_wait, gpmc_d_oe, csr_cs);
    end
    csr_dat_r = '0;
    idle_bus();
  endtask

  task automatic test_reset_read();
    int n0;
    open_acc(2'b10, 26'h0021);
    csr_dat_r = 16'h0F0F;
    gpmc_oe_n = 1'b0;
    tick(SS + LAT + 3);
    checks++;
    if ({gpmc_d_oe, gpmc_d_o} !== {1'b1, 16'h0F0F}) begin
      errors++;
      $display("FAIL rstrd_drive: oe=%b do=%h required 1 0f0f", gpmc_d_oe, gpmc_d_o);
    end
    sys_rst = 1'b1;
    tick(1);
    checks++;
    if ({csr_cs, csr_adr, csr_we, csr_re, csr_dat_w, gpmc_d_o, gpmc_d_oe, gpmc_wait} !== '0) begin
      errors++;
      $display("FAIL rstrd_zero: cs=%h adr=%h we=%b re=%b dw=%h do=%h oe=%b wait=%b required all 0",
               csr_cs, csr_adr, csr_we, csr_re, csr_dat_w, gpmc_d_o, gpmc_d_oe, gpmc_wait);
    end
    sys_rst   = 1'b0;
    gpmc_oe_n = 1'b1;
    csr_dat_r = '0;
    n0 = adr_q.size();
    open_acc(2'b10, 26'h0155);
    wr(16'h7777);
    checks++;
    if (adr_q.size() - n0 !== 1) begin
      errors++;
      $display("FAIL rstrd_next_count: got %0d writes required 1", adr_q.size() - n0);
    end else begin
      checks++;
      if ({cs_q[n0], adr_q[n0], dat_q[n0]} !== {2'b01, 14'h0155, 16'h7777}) begin
        errors++;
        $display("FAIL rstrd_next: cs=%b adr=%h dat=%h required 01 0155 7777",
                 cs_q[n0], adr_q[n0], dat_q[n0]);
      end
    end
    idle_bus();
  endtask

  initial begin
    sys_rst    = 1'b1;
    csr_dat_r  = '0;
    gpmc_a     = '0;
    gpmc_d_i   = '0;
    gpmc_we_n  = 1'b1;
    gpmc_oe_n  = 1'b1;
    gpmc_ale_n = 1'b1;
    gpmc_cs_n  = '1;
    test_reset();
    test_write();
    test_read();
    test_burst();
    test_cs_priority();
    test_read_abort();
    test_reset_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
